// File: rtl/video_timing_gen.sv
// Raster timing generator (hsync/vsync/DE/coords) with run/drain/idle scan-out control; VTG_FRAME_COUNT_EN builds the frame counter.
// Latency: all outputs are one register stage after the h/v counters and the FSM state.
// Backpressure: none; enable is sampled every cycle and scan-out only stops at the end of a frame.
module video_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 12
) (
    input  logic          clk_pixel,
    input  logic          rst_n,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          display_enable,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic          running,
    output logic [15:0]   frame_count
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_ACT   = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_END  = CW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_END  = CW'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic          HS_ON   = HSYNC_POL[0];
    localparam logic          VS_ON   = VSYNC_POL[0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] h;
    logic [CW-1:0] v;

    logic active;
    logic h_last;
    logic eof;
    logic de_nxt;
    logic hs_win;
    logic vs_win;

    assign active = (state != IDLE);
    assign h_last = (h == H_LAST);
    assign eof    = h_last && (v == V_LAST);
    assign de_nxt = active && (h < H_ACT) && (v < V_ACT);
    assign hs_win = (h >= HS_BEG) && (h < HS_END);
    assign vs_win = (v >= VS_BEG) && (v < VS_END);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            h              <= '0;
            v              <= '0;
            hsync          <= ~HS_ON;
            vsync          <= ~VS_ON;
            display_enable <= 1'b0;
            pixel_x        <= '0;
            pixel_y        <= '0;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
            vblank         <= 1'b1;
            running        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Counters stay at (0,0) so the first RUN cycle starts a clean frame.
                    if (enable) state <= RUN;
                end
                RUN, DRAIN: begin
                    h <= h_last ? '0 : h + 1'b1;
                    if (h_last) v <= (v == V_LAST) ? '0 : v + 1'b1;
                    // Re-enable during DRAIN takes priority, so a restored request never costs a frame.
                    if (enable)   state <= RUN;
                    else if (eof) state <= IDLE;
                    else          state <= DRAIN;
                end
                default: state <= IDLE;
            endcase

            hsync          <= (active && hs_win) ? HS_ON : ~HS_ON;
            vsync          <= (active && vs_win) ? VS_ON : ~VS_ON;
            display_enable <= de_nxt;
            pixel_x        <= de_nxt ? h : '0;
            pixel_y        <= de_nxt ? v : '0;
            line_start     <= active && (h == '0);
            frame_start    <= active && (h == '0) && (v == '0);
            vblank         <= !active || (v >= V_ACT);
            running        <= active;
        end
    end

`ifdef VTG_FRAME_COUNT_EN
    logic first_frame;

    // The frame started straight out of IDLE is not counted; every later frame_start is.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            first_frame <= 1'b1;
        end else if (!active) begin
            first_frame <= 1'b1;
        end else if ((h == '0) && (v == '0)) begin
            if (!first_frame) frame_count <= frame_count + 16'd1;
            first_frame <= 1'b0;
        end
    end
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Random enable stimulus on a small raster, checked cycle by cycle against a frame-position model.
module tb_video_timing_gen;
    localparam int HD = 32, HF = 2, HS = 4, HB = 2;
    localparam int VD = 8, VF = 1, VS = 1, VB = 1;
    localparam int HPOL = 1, VPOL = 0, CW = 12;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          clk_pixel = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          hsync, vsync, display_enable, line_start, frame_start, vblank, running;
    logic [CW-1:0] pixel_x, pixel_y;
    logic [15:0]   frame_count;

    video_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CW(CW)
    ) dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable),
        .hsync(hsync), .vsync(vsync), .display_enable(display_enable),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .line_start(line_start),
        .frame_start(frame_start), .vblank(vblank), .running(running),
        .frame_count(frame_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: scan-out is either off, or at linear position m_t within the frame.
    bit m_on;
    int m_t;
    bit m_first;
    int m_fc;
    int e_hs, e_vs, e_de, e_px, e_py, e_ls, e_fs, e_vb, e_run;

`ifdef VTG_FRAME_COUNT_EN
    localparam bit FC_LIVE = 1'b1;
`else
    localparam bit FC_LIVE = 1'b0;
`endif

    task automatic model_reset();
        m_on = 0; m_t = 0; m_first = 1; m_fc = 0;
        e_hs = ~HPOL & 1; e_vs = ~VPOL & 1; e_de = 0; e_px = 0; e_py = 0;
        e_ls = 0; e_fs = 0; e_vb = 1; e_run = 0;
    endtask

    task automatic model_edge(input bit en);
        int x, y;
        x = m_t % HT;
        y = m_t / HT;
        e_run = m_on;
        if (!m_on) begin
            e_hs = ~HPOL & 1; e_vs = ~VPOL & 1; e_de = 0; e_px = 0; e_py = 0;
            e_ls = 0; e_fs = 0; e_vb = 1;
            m_first = 1;
        end else begin
            e_de = (x < HD) && (y < VD);
            e_px = e_de ? x : 0;
            e_py = e_de ? y : 0;
            e_hs = (x >= HD + HF && x < HD + HF + HS) ? HPOL : (~HPOL & 1);
            e_vs = (y >= VD + VF && y < VD + VF + VS) ? VPOL : (~VPOL & 1);
            e_ls = (x == 0);
            e_fs = (m_t == 0);
            e_vb = (y >= VD);
            if (m_t == 0) begin
                if (!m_first && FC_LIVE) m_fc = (m_fc + 1) % 65536;
                m_first = 0;
            end
        end
        // Scan-out only stops after the last pixel of a frame with no request present.
        if (!m_on) begin
            if (en) begin m_on = 1; m_t = 0; end
        end else begin
            if (m_t == FT - 1 && !en) m_on = 0;
            m_t = (m_t + 1) % FT;
            if (!m_on) m_t = 0;
        end
    endtask

    task automatic compare_all();
        check("hsync", hsync, e_hs);
        check("vsync", vsync, e_vs);
        check("de", display_enable, e_de);
        check("pixel_x", pixel_x, e_px);
        check("pixel_y", pixel_y, e_py);
        check("line_start", line_start, e_ls);
        check("frame_start", frame_start, e_fs);
        check("vblank", vblank, e_vb);
        check("running", running, e_run);
        check("frame_count", frame_count, m_fc);
    endtask

    int cyc = 0;

    task automatic step();
        @(posedge clk_pixel);
        model_edge(enable);
        cyc++;
        #1;
        compare_all();
    endtask

    int last_fs;
    int n_fs;
    bit hit;

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_pixel);
        #1;
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 1);
        check("rst_vblank", vblank, 1);
        check("rst_running", running, 0);
        check("rst_frame_count", frame_count, 0);

        // Release with enable already high: frame_start appears two edges later.
        rst_n = 1'b1;
        enable = 1'b1;
        step();
        check("first_fs_early", frame_start, 0);
        step();
        check("first_fs", frame_start, 1);
        last_fs = cyc;
        for (int i = 0; i < 3 * FT; i++) begin
            step();
            if (frame_start) begin
                check("fs_period", cyc - last_fs, FT);
                last_fs = cyc;
            end
        end

        // Random enable drops and restores, including ones spanning frame ends.
        for (int i = 0; i < 6000; i++) begin
            step();
            if ($urandom_range(0, 149) == 0) enable = ~enable;
        end
        enable = 1'b0;
        for (int i = 0; i < FT + 5; i++) step();
        check("drained_idle", running, 0);

        // Asynchronous reset in the middle of a frame.
        enable = 1'b1;
        hit = 0;
        for (int i = 0; i < 3 * FT && !hit; i++) begin
            step();
            if (m_on && m_t == 5 * HT + 17) hit = 1;
        end
        check("reset_point_reached", hit, 1);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("arst_running", running, 0);
        @(posedge clk_pixel);
        #1 rst_n = 1'b1;
        n_fs = 0;
        for (int i = 0; i < 5 * FT && n_fs < 4; i++) begin
            step();
            if (frame_start) n_fs++;
        end
        check("four_frames_seen", n_fs, 4);
        check("fc_after_4_frames", frame_count, FC_LIVE ? 3 : 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator; next generation of the fixed 640×480@60 display timing block. Timing geometry, sync polarity and counter width are set by parameters. All outputs are registered (glitch-free to the DVI/TMDS encoder). A run/drain/idle controller starts and stops scan-out only on frame boundaries. Sits in the display pipeline on clk_pixel, feeding the scan-out fetch unit and the TMDS encoder.

Parameters:
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level (0 = active-low)
CW, 12, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk_pixel  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  request scan-out; sampled every cycle
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
display_enable  out  1  active-area flag
pixel_x  out  CW  active-area X; 0 outside active area
pixel_y  out  CW  active-area Y; 0 outside active area
line_start  out  1  one-cycle pulse at h=0 of every line, including blanking lines
frame_start  out  1  one-cycle pulse at h=0, v=0
vblank  out  1  high while v >= V_DISPLAY
running  out  1  controller not in IDLE
frame_count  out  16  completed-frame counter (see Optional Feature)

Behaviour:
- Derived values: H_TOTAL = sum of the four H_* values; V_TOTAL = sum of the four V_* values. Sync windows: h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC); v likewise.
- Counters h, v (CW bits). h wraps at H_TOTAL-1. v increments when h == H_TOTAL-1 and wraps at V_TOTAL-1. Both are held at 0 in IDLE.
- FSM states:
  - IDLE: enable=1 -> RUN; counters are (0,0) on the first RUN cycle.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: counters keep running. enable=1 -> RUN with no disturbance to timing. At h=H_TOTAL-1 and v=V_TOTAL-1 (end of frame) -> IDLE.
  - A RUN cycle at end of frame with enable=0 goes straight to IDLE.
- Outputs are one register stage after the counters: outputs at cycle n+1 decode (h,v,state) at cycle n.
- IDLE outputs: hsync/vsync at inactive level; display_enable, line_start, frame_start, pixel_x, pixel_y = 0; vblank = 1.
- Reset (async, any time including mid-frame): FSM to IDLE, counters 0, all outputs at IDLE values, running = 0, frame_count = 0.
- running is registered and equals (state != IDLE) delayed one cycle, aligned with the other outputs.
- frame_count increments (wraps modulo 2^16) in the cycle frame_start is output, except on the first frame after leaving IDLE.

Optional Feature:
VTG_FRAME_COUNT_EN
- Defined: frame_count is a live 16-bit counter as described above.
- Undefined: frame_count is constant 0 and no counter register is built.
- All other behaviour is identical in both builds.

Test Plan:
- Reset release with enable=1 at cycle 0: FSM is in RUN at cycle 1 with counters (0,0). frame_start=1 and line_start=1 at cycle 2. hsync low for cycles 2+656..2+751 (96 cycles). display_enable is high for exactly 640 cycles per line on lines 0-479.
- Full frame at defaults: 800×525 = 420000 cycles between frame_start pulses. vsync low for exactly 1600 cycles starting at line 490. vblank high for 45 lines.
- Build with HSYNC_POL=1, H_DISPLAY=32, H_FRONT=2, H_SYNC=4, H_BACK=2, V_DISPLAY=8, V_FRONT=1, V_SYNC=1, V_BACK=1: line period is 40 cycles, frame period 440 cycles. hsync high for h=34..37. pixel_x counts 0..31, then 0.
- Drop enable mid-frame at line 100: running stays 1 until the end of line 524. The next cycle returns to IDLE outputs (vblank=1, syncs inactive, running=0 one cycle later). No frame_start pulse follows.
- Drop enable at line 100, re-raise at line 200: no gap. frame_start occurs exactly 420000 cycles after the previous one.
- Assert rst_n low at h=300, v=250: all outputs go immediately to IDLE values and frame_count=0. With VTG_FRAME_COUNT_EN defined, after reset frame_count reads 3 at the 4th frame_start. Undefined: frame_count reads 0 throughout.
